pipeline_reg_mem: RTL

Memory-stage pipeline register. It sits directly downstream of the execute-stage register and consumes its registered rd select, write enable and ALU result. It performs the load/store access to data memory over a req/ready handshake, stalling upstream while waiting. It presents formatted results to the writeback stage.

---
 rtl/pipeline_reg_mem.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/pipeline_reg_mem.sv
// Memory-stage pipeline register: accepts execute-stage results, runs load/store
// accesses over a req/ready handshake with a wait limit, and formats writeback results.
module pipeline_reg_mem #(
    parameter int WAIT_LIMIT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic        ex_write_enable,
    input  logic [4:0]  ex_rd_sel,
    input  logic [31:0] ex_alu_result,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [1:0]  ex_mem_size,
    input  logic        ex_load_unsigned,
    input  logic [31:0] ex_store_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_write_enable,
    output logic [4:0]  wb_rd_sel,
    output logic [31:0] wb_value,
    output logic        wb_fault
);

    typedef enum logic {S_IDLE = 1'b0, S_REQ = 1'b1} state_t;

    localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

    state_t      r_state, w_state_next;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_inc;
    logic        w_is_mem, w_misaligned, w_accept, w_done, w_timeout;

    logic        r_we, r_store, r_uns;
    logic [4:0]  r_rd;
    logic [1:0]  r_size;
    logic [31:0] r_addr, r_wdata;
    logic [3:0]  r_wstrb;

    logic        r_wb_valid, r_wb_we, r_wb_fault;
    logic [4:0]  r_wb_rd;
    logic [31:0] r_wb_value;

    function automatic logic [31:0] fmt_load(input logic [31:0] rdata, input logic [1:0] lane,
                                             input logic [1:0] size, input logic uns);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        shifted = rdata >> {lane, 3'b000};
        b = shifted[7:0];
        h = shifted[15:0];
        case (size)
            2'b00:   return uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   return uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: return rdata;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input logic [31:0] d, input logic [1:0] size);
        case (size)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [3:0] store_strb(input logic [1:0] lane, input logic [1:0] size);
        case (size)
            2'b00:   return 4'b0001 << lane;
            2'b01:   return 4'b0011 << lane;
            default: return 4'b1111;
        endcase
    endfunction

    assign w_is_mem     = ex_mem_read | ex_mem_write;
    assign w_misaligned = (ex_mem_size == 2'b11) |
                          ((ex_mem_size == 2'b01) & ex_alu_result[0]) |
                          ((ex_mem_size == 2'b10) & (|ex_alu_result[1:0]));
    assign w_accept     = ex_ready & ex_valid;
    assign w_cnt_inc    = r_cnt + 8'd1;
    assign w_done       = (r_state == S_REQ) & dmem_ready;
    // Ready on the limit cycle wins: timeout only fires when ready is low.
    assign w_timeout    = (r_state == S_REQ) & ~dmem_ready & (w_cnt_inc >= LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_REQ && !w_done && !w_timeout) r_cnt <= w_cnt_inc;
            else                                           r_cnt <= '0;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (ex_valid & w_is_mem & ~w_misaligned) w_state_next = S_REQ;
            S_REQ:   if (w_done | w_timeout) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        ex_ready = 1'b0;
        dmem_req = 1'b0;
        case (r_state)
            S_IDLE:  ex_ready = rst_n;
            S_REQ:   dmem_req = 1'b1;
            default: ex_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we       <= 1'b0;
            r_store    <= 1'b0;
            r_uns      <= 1'b0;
            r_rd       <= '0;
            r_size     <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_wb_valid <= 1'b0;
            r_wb_we    <= 1'b0;
            r_wb_fault <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_value <= '0;
        end else begin
            r_wb_valid <= 1'b0;
            if (w_accept) begin
                r_we    <= ex_write_enable;
                r_store <= ex_mem_write;
                r_uns   <= ex_load_unsigned;
                r_rd    <= ex_rd_sel;
                r_size  <= ex_mem_size;
                r_addr  <= ex_alu_result;
                r_wdata <= store_wdata(ex_store_data, ex_mem_size);
                r_wstrb <= store_strb(ex_alu_result[1:0], ex_mem_size);
                if (!w_is_mem || w_misaligned) begin
                    r_wb_valid <= 1'b1;
                    r_wb_rd    <= ex_rd_sel;
                    r_wb_value <= ex_alu_result;
                    r_wb_fault <= w_is_mem;
                    r_wb_we    <= ~w_is_mem & ex_write_enable & (|ex_rd_sel);
                end
            end else if (w_done) begin
                r_wb_valid <= 1'b1;
                r_wb_rd    <= r_rd;
                r_wb_fault <= 1'b0;
                r_wb_we    <= ~r_store & r_we & (|r_rd);
                r_wb_value <= r_store ? r_addr : fmt_load(dmem_rdata, r_addr[1:0], r_size, r_uns);
            end else if (w_timeout) begin
                r_wb_valid <= 1'b1;
                r_wb_rd    <= r_rd;
                r_wb_fault <= 1'b1;
                r_wb_we    <= 1'b0;
                r_wb_value <= r_addr;
            end
        end
    end

    assign dmem_we         = r_store;
    assign dmem_addr       = {r_addr[31:2], 2'b00};
    assign dmem_wdata      = r_wdata;
    assign dmem_wstrb      = r_wstrb;
    assign wb_valid        = r_wb_valid;
    assign wb_write_enable = r_wb_we;
    assign wb_rd_sel       = r_wb_rd;
    assign wb_value        = r_wb_value;
    assign wb_fault        = r_wb_fault;

endmodule
